// File: rtl/spi_mem_master.sv
// SPI mode-0 master: performs one 32-bit word read or write to a serial SRAM/flash.
// Each frame is an 8-bit command, a 24-bit address and 4 data bytes, sent MSB-first.
module spi_mem_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        spi_cs,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // Handshake: a request is accepted on a rising clk edge where req_valid and
    // req_ready are both high; rsp_valid is a single-cycle strobe with no backpressure.

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] BIT_LAST  = 9'(2 * CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [8:0]  div_cnt, div_nxt;
    logic [6:0]  bit_cnt, bit_nxt;
    logic [63:0] tx, tx_nxt;
    logic [31:0] rx, rx_nxt;
    logic        is_write, is_write_nxt;
    logic        cs_nxt, sck_nxt, mosi_nxt, rsp_valid_nxt;
    logic [31:0] rdata_nxt;

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        div_nxt       = div_cnt;
        bit_nxt       = bit_cnt;
        tx_nxt        = tx;
        rx_nxt        = rx;
        is_write_nxt  = is_write;
        cs_nxt        = spi_cs;
        sck_nxt       = spi_sck;
        mosi_nxt      = spi_mosi;
        rsp_valid_nxt = 1'b0;
        rdata_nxt     = rsp_rdata;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt    = SETUP;
                    is_write_nxt = req_write;
                    // Data bytes go out least-significant byte first; reads clock out zeros.
                    tx_nxt       = {req_write ? CMD_WRITE : CMD_READ, req_addr,
                                    req_write ? {req_wdata[7:0], req_wdata[15:8],
                                                 req_wdata[23:16], req_wdata[31:24]} : 32'h0};
                    mosi_nxt     = req_write ? CMD_WRITE[7] : CMD_READ[7];
                    cs_nxt       = 1'b0;
                    sck_nxt      = 1'b0;
                    div_nxt      = '0;
                    bit_nxt      = '0;
                end
            end
            SETUP: begin
                if (div_cnt == HALF_LAST) begin
                    state_nxt = SHIFT;
                    sck_nxt   = 1'b1;
                    rx_nxt    = {rx[30:0], spi_miso};
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + 9'd1;
                end
            end
            SHIFT: begin
                if (div_cnt == HALF_LAST) begin
                    sck_nxt = 1'b0;
                    div_nxt = div_cnt + 9'd1;
                    if (bit_cnt != 7'd63) begin
                        mosi_nxt = tx[62];
                        tx_nxt   = {tx[62:0], 1'b0};
                    end
                end else if (div_cnt == BIT_LAST) begin
                    div_nxt = '0;
                    if (bit_cnt == 7'd63) begin
                        state_nxt = HOLD;
                        mosi_nxt  = 1'b0;
                    end else begin
                        sck_nxt = 1'b1;
                        rx_nxt  = {rx[30:0], spi_miso};
                        bit_nxt = bit_cnt + 7'd1;
                    end
                end else begin
                    div_nxt = div_cnt + 9'd1;
                end
            end
            HOLD: begin
                if (div_cnt == HALF_LAST) begin
                    state_nxt     = GAP;
                    cs_nxt        = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    div_nxt       = '0;
                    // rx holds b0..b3 in arrival order; b0 lands in the low byte.
                    if (!is_write) begin
                        rdata_nxt = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                    end
                end else begin
                    div_nxt = div_cnt + 9'd1;
                end
            end
            GAP: begin
                if (div_cnt == HALF_LAST) begin
                    state_nxt = IDLE;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + 9'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            is_write  <= 1'b0;
            spi_cs    <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            tx        <= tx_nxt;
            rx        <= rx_nxt;
            is_write  <= is_write_nxt;
            spi_cs    <= cs_nxt;
            spi_sck   <= sck_nxt;
            spi_mosi  <= mosi_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rdata_nxt;
        end
    end

endmodule
